// File: rtl/rr_mux_feeder_if.sv
// Bundle of the two source streams and the registered {data, sel} output stream
// of rr_mux_feeder. The master modport is the feeder's view, slave is the environment's.
interface rr_mux_feeder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_sel;
  logic             out_valid;
  logic             out_ready;

  modport master (
    input  a_data, a_valid, b_data, b_valid, out_ready,
    output a_ready, b_ready, out_data, out_sel, out_valid
  );

  modport slave (
    output a_data, a_valid, b_data, b_valid, out_ready,
    input  a_ready, b_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/rr_mux_feeder.sv
// Burst-limited round-robin arbiter between sources A and B feeding a registered
// {data, sel} word to a downstream 2:1 mux at up to one word per cycle.
module rr_mux_feeder #(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  rr_mux_feeder_if.master bus
);
  // Valid/ready: a word moves on any rising edge where valid && ready are both high;
  // ready never depends on data, and a source holds data/valid until accepted.

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  localparam logic [3:0] BURST_MAX = 4'(BURST - 1);

  src_e             last_src_q, last_src_d;
  logic [3:0]       burst_cnt_q, burst_cnt_d;
  logic             started_q, started_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;

  logic load_en;
  logic grant_vld;
  src_e grant_src;

  // Until the first grant after reset no burst is running, so contention goes to A.
  always_comb begin
    load_en   = !out_valid_q || bus.out_ready;
    grant_vld = 1'b0;
    grant_src = SRC_A;
    if (load_en) begin
      if (bus.a_valid && bus.b_valid) begin
        grant_vld = 1'b1;
        if (started_q && (burst_cnt_q < BURST_MAX)) begin
          grant_src = last_src_q;
        end else begin
          grant_src = (last_src_q == SRC_A) ? SRC_B : SRC_A;
        end
      end else if (bus.a_valid) begin
        grant_vld = 1'b1;
        grant_src = SRC_A;
      end else if (bus.b_valid) begin
        grant_vld = 1'b1;
        grant_src = SRC_B;
      end
    end
  end

  assign bus.a_ready = rst_n && grant_vld && (grant_src == SRC_A);
  assign bus.b_ready = rst_n && grant_vld && (grant_src == SRC_B);

  always_comb begin
    last_src_d  = last_src_q;
    burst_cnt_d = burst_cnt_q;
    started_d   = started_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    if (grant_vld) begin
      out_data_d  = (grant_src == SRC_B) ? bus.b_data : bus.a_data;
      out_sel_d   = (grant_src == SRC_B);
      out_valid_d = 1'b1;
      started_d   = 1'b1;
      if (grant_src == last_src_q) begin
        burst_cnt_d = (burst_cnt_q < BURST_MAX) ? burst_cnt_q + 4'd1 : burst_cnt_q;
      end else begin
        burst_cnt_d = 4'd0;
        last_src_d  = grant_src;
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_src_q  <= SRC_B;
      burst_cnt_q <= 4'd0;
      started_q   <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      last_src_q  <= last_src_d;
      burst_cnt_q <= burst_cnt_d;
      started_q   <= started_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;
endmodule
